// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one GCD core among NREQ requesters.
// Zero operands are answered locally; a watchdog bounds every core transaction.
module gcd_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   op_a,
   input  logic [NREQ*WIDTH-1:0]   op_b,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [WIDTH-1:0]        rsp_data,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    core_start,
   output logic [WIDTH-1:0]        core_a,
   output logic [WIDTH-1:0]        core_b,
   input  logic                    core_done,
   input  logic [WIDTH-1:0]        core_res
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [IDX_W-1:0]   r_last, w_last_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [NREQ-1:0]    r_gnt, w_gnt_nxt;
   logic [NREQ-1:0]    r_rsp_valid, w_rsp_valid_nxt;
   logic [WIDTH-1:0]   r_rsp_data, w_rsp_data_nxt;
   logic               r_rsp_err, w_rsp_err_nxt;
   logic               r_busy;
   logic               r_core_start, w_core_start_nxt;
   logic [WIDTH-1:0]   r_core_a, w_core_a_nxt;
   logic [WIDTH-1:0]   r_core_b, w_core_b_nxt;

   logic [WIDTH-1:0]   w_a_arr [NREQ];
   logic [WIDTH-1:0]   w_b_arr [NREQ];
   logic [IDX_W-1:0]   w_j;
   logic [IDX_W-1:0]   w_win;
   logic               w_found;
   logic [WIDTH-1:0]   w_win_a;
   logic [WIDTH-1:0]   w_win_b;

   function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Unpack the flat operand buses into per-requester slices
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_a_arr[i] = op_a[i*WIDTH +: WIDTH];
         w_b_arr[i] = op_b[i*WIDTH +: WIDTH];
      end
   end

   // Round-robin search: scan from farthest to nearest so the nearest set bit after r_last wins
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_j     = '0;
      for (int k = NREQ; k >= 1; k--) begin
         w_j     = IDX_W'((int'(r_last) + k) % NREQ);
         w_found = w_found | req[w_j];
         w_win   = req[w_j] ? w_j : w_win;
      end
      w_win_a = w_a_arr[w_win];
      w_win_b = w_b_arr[w_win];
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-output decode; all pulse outputs default low
   always_comb begin
      w_state_nxt      = r_state;
      w_idx_nxt        = r_idx;
      w_last_nxt       = r_last;
      w_cnt_nxt        = r_cnt;
      w_gnt_nxt        = '0;
      w_rsp_valid_nxt  = '0;
      w_rsp_data_nxt   = '0;
      w_rsp_err_nxt    = 1'b0;
      w_core_start_nxt = 1'b0;
      w_core_a_nxt     = r_core_a;
      w_core_b_nxt     = r_core_b;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_idx_nxt = w_win;
               w_gnt_nxt = onehot(w_win);
               if ((w_win_a == '0) || (w_win_b == '0)) begin
                  // Zero operand: answer directly, the core never sees it
                  w_state_nxt     = S_RESP;
                  w_rsp_valid_nxt = onehot(w_win);
                  w_rsp_data_nxt  = (w_win_a == '0) ? w_win_b : w_win_a;
                  w_rsp_err_nxt   = (w_win_a == '0) && (w_win_b == '0);
               end else begin
                  w_state_nxt      = S_ISSUE;
                  w_core_start_nxt = 1'b1;
                  w_core_a_nxt     = w_win_a;
                  w_core_b_nxt     = w_win_b;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ISSUE: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (core_done) begin
               w_state_nxt     = S_RESP;
               w_rsp_valid_nxt = onehot(r_idx);
               w_rsp_data_nxt  = core_res;
               w_rsp_err_nxt   = 1'b0;
               w_core_a_nxt    = '0;
               w_core_b_nxt    = '0;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_state_nxt     = S_RESP;
               w_rsp_valid_nxt = onehot(r_idx);
               w_rsp_data_nxt  = '0;
               w_rsp_err_nxt   = 1'b1;
               w_core_a_nxt    = '0;
               w_core_b_nxt    = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
            w_last_nxt  = r_idx;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Registered outputs and transaction context
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx        <= '0;
         r_last       <= IDX_W'(NREQ - 1);
         r_cnt        <= '0;
         r_gnt        <= '0;
         r_rsp_valid  <= '0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_busy       <= 1'b0;
         r_core_start <= 1'b0;
         r_core_a     <= '0;
         r_core_b     <= '0;
      end else begin
         r_idx        <= w_idx_nxt;
         r_last       <= w_last_nxt;
         r_cnt        <= w_cnt_nxt;
         r_gnt        <= w_gnt_nxt;
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_data   <= w_rsp_data_nxt;
         r_rsp_err    <= w_rsp_err_nxt;
         r_busy       <= (w_state_nxt != S_IDLE);
         r_core_start <= w_core_start_nxt;
         r_core_a     <= w_core_a_nxt;
         r_core_b     <= w_core_b_nxt;
      end
   end

   assign gnt        = r_gnt;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;
   assign busy       = r_busy;
   assign core_start = r_core_start;
   assign core_a     = r_core_a;
   assign core_b     = r_core_b;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model that timestamps grant and response edges.
module tb_gcd_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 5;
   localparam int TIMEOUT = 64;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] op_a, op_b;
   logic [NREQ-1:0]       gnt, rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err, busy, core_start;
   logic [WIDTH-1:0]      core_a, core_b;
   logic                  core_done;
   logic [WIDTH-1:0]      core_res;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // core model controls
   int               core_mode = 0;   // 0: answers after core_lat cycles, 1: silent
   int               core_lat  = 3;
   int               core_cnt  = 0;
   bit               inject    = 1'b0;
   logic [WIDTH-1:0] inject_res = '0;
   logic [WIDTH-1:0] ca = '0, cb = '0;

   // reference model: one outstanding transaction with edge timestamps
   int               m_last = NREQ - 1;
   int               m_idx  = 0;
   int               m_e    = 0;
   int               m_resp = -1;
   int               m_free = 0;
   bit               m_active = 1'b0;
   bit               m_bypass = 1'b0;
   logic [WIDTH-1:0] m_a = '0, m_b = '0, m_res = '0;
   logic             m_err = 1'b0;

   gcd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy), .core_start(core_start), .core_a(core_a), .core_b(core_b),
      .core_done(core_done), .core_res(core_res)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [WIDTH-1:0] gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] x, y, t;
      x = a;
      y = b;
      while (y != '0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic set_op(input int i, input int a, input int b);
      op_a[i*WIDTH +: WIDTH] = WIDTH'(a);
      op_b[i*WIDTH +: WIDTH] = WIDTH'(b);
   endtask

   task automatic wait_sig(input bit want_rsp, input int maxc, output int t);
      t = -1;
      for (int i = 0; i < maxc; i++) begin
         @(posedge clk);
         #2;
         if ((want_rsp ? rsp_valid : gnt) != '0) begin
            t = cyc;
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL %s: nothing within %0d cycles at cycle %0d", want_rsp ? "wait_rsp" : "wait_gnt", maxc, cyc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // GCD core stand-in: captures operands on core_start, answers after core_lat cycles
   initial begin
      core_done = 1'b0;
      core_res  = '0;
      forever begin
         @(negedge clk);
         core_done = 1'b0;
         if (rst !== 1'b1) begin
            core_cnt = 0;
         end else if (core_start && core_mode == 0) begin
            core_cnt = core_lat;
            ca = core_a;
            cb = core_b;
         end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
               core_done = 1'b1;
               core_res  = gcd(ca, cb);
            end
         end
         if (inject) begin
            core_done = 1'b1;
            core_res  = inject_res;
            inject    = 1'b0;
         end
      end
   end

   // Model update on each edge, then compare every DUT output just after the edge
   initial begin
      logic [NREQ-1:0]       s_req, e_gnt, e_rv;
      logic [NREQ*WIDTH-1:0] s_a, s_b;
      logic                  s_done;
      logic [WIDTH-1:0]      s_res;
      int                    j;
      bit                    found;
      forever begin
         @(posedge clk);
         cyc++;
         s_req  = req;
         s_a    = op_a;
         s_b    = op_b;
         s_done = core_done;
         s_res  = core_res;
         if (rst !== 1'b1) begin
            m_last   = NREQ - 1;
            m_active = 1'b0;
            m_free   = 0;
            m_resp   = -1;
         end else begin
            if (m_active && !m_bypass && m_resp < 0 && cyc >= m_e + 2) begin
               if (s_done) begin
                  m_resp = cyc;
                  m_res  = s_res;
                  m_err  = 1'b0;
               end else if (cyc == m_e + 1 + TIMEOUT) begin
                  m_resp = cyc;
                  m_res  = '0;
                  m_err  = 1'b1;
               end
            end
            if (m_active && m_resp >= 0 && cyc == m_resp + 1) begin
               m_last   = m_idx;
               m_active = 1'b0;
               m_free   = cyc + 1;
            end
            if (!m_active && cyc >= m_free && s_req != '0) begin
               found = 1'b0;
               for (int k = 1; k <= NREQ; k++) begin
                  j = (m_last + k) % NREQ;
                  if (!found && s_req[j]) begin
                     found = 1'b1;
                     m_idx = j;
                  end
               end
               m_a      = s_a[m_idx*WIDTH +: WIDTH];
               m_b      = s_b[m_idx*WIDTH +: WIDTH];
               m_e      = cyc;
               m_active = 1'b1;
               m_bypass = (m_a == '0) || (m_b == '0);
               if (m_bypass) begin
                  m_resp = cyc;
                  m_res  = (m_a == '0) ? m_b : m_a;
                  m_err  = (m_a == '0) && (m_b == '0);
               end else begin
                  m_resp = -1;
               end
            end
         end
         #1;
         e_gnt = '0;
         e_rv  = '0;
         if (m_active && cyc == m_e) e_gnt[m_idx] = 1'b1;
         if (m_active && cyc == m_resp) e_rv[m_idx] = 1'b1;
         chk("gnt", gnt, e_gnt);
         chk("rsp_valid", rsp_valid, e_rv);
         chk("core_start", core_start, m_active && !m_bypass && cyc == m_e);
         chk("busy", busy, m_active);
         if (rst !== 1'b1) begin
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_core_a", core_a, 0);
            chk("rst_core_b", core_b, 0);
         end else if (e_rv != '0) begin
            chk("rsp_data", rsp_data, m_res);
            chk("rsp_err", rsp_err, m_err);
         end else if (m_active && !m_bypass && m_resp < 0) begin
            chk("core_a", core_a, m_a);
            chk("core_b", core_b, m_b);
         end
      end
   end

   initial begin
      int t0, t1, t2;
      logic [NREQ-1:0] ord [5];
      ord[0] = 4'b0001; ord[1] = 4'b0010; ord[2] = 4'b0100; ord[3] = 4'b1000; ord[4] = 4'b0001;
      rst  = 1'b1;
      req  = '0;
      op_a = '0;
      op_b = '0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_gnt", gnt, 4'b0000);
      chk("reset_rsp_valid", rsp_valid, 4'b0000);
      chk("reset_busy", busy, 1'b0);
      chk("reset_core_start", core_start, 1'b0);

      // single normal transaction, core answers 8 after 3 cycles
      req = 4'b0001;
      set_op(0, 8, 8);
      core_lat = 3;
      rst = 1'b1;
      wait_sig(1'b0, 10, t0);
      chk("t1_gnt", gnt, 4'b0001);
      chk("t1_core_start", core_start, 1'b1);
      chk("t1_core_a", core_a, 8);
      chk("t1_core_b", core_b, 8);
      req = '0;
      wait_sig(1'b1, 20, t1);
      chk("t1_rsp_valid", rsp_valid, 4'b0001);
      chk("t1_rsp_data", rsp_data, 8);
      chk("t1_rsp_err", rsp_err, 1'b0);
      chk("t1_latency", t1 - t0, 4);

      // all four requesting: rotation 0,1,2,3,0
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) set_op(i, 12, 8);
      for (int n = 0; n < 5; n++) begin
         wait_sig(1'b0, 10, t0);
         chk("t2_gnt_order", gnt, ord[n]);
         if (n == 4) req = '0;
         wait_sig(1'b1, 20, t1);
         chk("t2_rsp_data", rsp_data, 4);
      end

      // serve 2, then 0101 wraps to 0 before 2
      req = 4'b0100;
      set_op(2, 9, 6);
      wait_sig(1'b0, 10, t0);
      chk("t3_gnt2", gnt, 4'b0100);
      req = '0;
      wait_sig(1'b1, 20, t1);
      chk("t3_data2", rsp_data, 3);
      req = 4'b0101;
      set_op(0, 10, 4);
      wait_sig(1'b0, 10, t0);
      chk("t3_gnt_wrap", gnt, 4'b0001);
      wait_sig(1'b1, 20, t1);
      chk("t3_data0", rsp_data, 2);
      wait_sig(1'b0, 10, t0);
      chk("t3_gnt_next", gnt, 4'b0100);
      req = '0;
      wait_sig(1'b1, 20, t1);
      chk("t3_data2b", rsp_data, 3);

      // zero-operand bypass and back-to-back spacing
      req = 4'b0010;
      set_op(1, 0, 12);
      wait_sig(1'b0, 10, t0);
      chk("t4_gnt", gnt, 4'b0010);
      chk("t4_rsp_valid", rsp_valid, 4'b0010);
      chk("t4_rsp_data", rsp_data, 12);
      chk("t4_rsp_err", rsp_err, 1'b0);
      chk("t4_no_start", core_start, 1'b0);
      set_op(1, 0, 0);
      wait_sig(1'b0, 10, t1);
      chk("t4_spacing", t1 - t0, 2);
      chk("t4_zz_rsp_valid", rsp_valid, 4'b0010);
      chk("t4_zz_data", rsp_data, 0);
      chk("t4_zz_err", rsp_err, 1'b1);
      wait_sig(1'b0, 10, t2);
      chk("t4_spacing2", t2 - t1, 2);
      req = '0;

      // watchdog: silent core
      core_mode = 1;
      req = 4'b0001;
      set_op(0, 9, 6);
      wait_sig(1'b0, 10, t0);
      req = '0;
      wait_sig(1'b1, 80, t1);
      chk("t5_rsp_valid", rsp_valid, 4'b0001);
      chk("t5_latency", t1 - t0, 65);
      chk("t5_rsp_data", rsp_data, 0);
      chk("t5_rsp_err", rsp_err, 1'b1);
      @(posedge clk);
      #2;
      inject_res = 5'd7;
      inject = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #2;
         chk("t5_late_done_busy", busy, 1'b0);
         chk("t5_late_done_rsp", rsp_valid, 4'b0000);
      end

      // reset while waiting on the core
      req = 4'b1000;
      set_op(3, 10, 15);
      wait_sig(1'b0, 10, t0);
      chk("t6_gnt", gnt, 4'b1000);
      req = '0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6_abort_busy", busy, 1'b0);
      chk("t6_abort_core_a", core_a, 0);
      chk("t6_abort_core_b", core_b, 0);
      chk("t6_abort_gnt", gnt, 4'b0000);
      chk("t6_abort_rsp", rsp_valid, 4'b0000);
      repeat (2) @(negedge clk);
      req = 4'b1001;
      set_op(0, 6, 4);
      core_mode = 0;
      core_lat = 2;
      rst = 1'b1;
      wait_sig(1'b0, 10, t0);
      chk("t6_gnt_after_reset", gnt, 4'b0001);
      wait_sig(1'b1, 20, t1);
      chk("t6_data0", rsp_data, 2);
      wait_sig(1'b0, 10, t0);
      chk("t6_gnt3", gnt, 4'b1000);
      req = '0;
      wait_sig(1'b1, 20, t1);
      chk("t6_data3", rsp_data, 5);

      // random traffic, stray core_done pulses, occasional silent core
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #3;
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            if ($urandom_range(0, 3) == 0) begin
               set_op(i, ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 31)),
                         ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 31)));
            end
         end
         core_lat  = int'($urandom_range(1, 6));
         core_mode = ($urandom_range(0, 99) == 0) ? 1 : 0;
         if ($urandom_range(0, 31) == 0) begin
            inject_res = WIDTH'($urandom_range(0, 31));
            inject = 1'b1;
         end
      end
      req = '0;
      core_mode = 0;
      repeat (100) @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
Round-robin scheduler that shares one GCD core among NREQ requesters. It samples requests, latches the winner's operands and sequences the core's start/done handshake. It returns the result to the winning requester and resolves zero-operand cases without using the core. A watchdog bounds every core transaction. It sits between the requesting blocks and the single GCD core instance.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 5, operand/result width in bits
TIMEOUT, 64, max cycles in WAIT before error response (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request level
op_a  input  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
op_b  input  NREQ*WIDTH  operand B, same packing
gnt  output  NREQ  one-hot, 1-cycle pulse: winner's operands captured
rsp_valid  output  NREQ  one-hot, 1-cycle pulse: response for requester i
rsp_data  output  WIDTH  result, valid with rsp_valid
rsp_err  output  1  error flag, valid with rsp_valid
busy  output  1  high whenever state != IDLE
core_start  output  1  1-cycle start pulse to GCD core
core_a  output  WIDTH  operand A to core, held ISSUE..WAIT
core_b  output  WIDTH  operand B to core, held ISSUE..WAIT
core_done  input  1  core completion pulse
core_res  input  WIDTH  core result, valid with core_done

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Timeout counter 0. Last-grant pointer = NREQ-1, so requester 0 has top priority. The core itself is not reset by this block.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req is sampled only here.
  - If req != 0, the winner is the first set bit searching from (last+1) mod NREQ upward with wrap.
  - On that edge, latch the winner index, op_a and op_b slices.
  - Next cycle: gnt[idx]=1 for one cycle.
  - Next state: RESP if either operand is 0, else ISSUE.
- Zero-operand bypass (core is never started):
  - A=0, B!=0: rsp_data=B, err=0.
  - B=0, A!=0: rsp_data=A, err=0.
  - A=B=0: rsp_data=0, err=1.
- ISSUE (1 cycle): core_start=1, core_a/core_b = latched operands. Timeout counter cleared. Next state WAIT.
- WAIT:
  - core_a/core_b are held and the counter increments each cycle.
  - On core_done=1: latch core_res, err=0, go to RESP.
  - Else when the counter reaches TIMEOUT-1: data=0, err=1, go to RESP.
  - core_done and timeout in the same cycle: done wins.
- RESP (1 cycle): rsp_valid[idx]=1 with rsp_data/rsp_err. Last pointer = idx. Next state IDLE.
- Latency, normal path: req sampled at edge 0 -> gnt and core_start in cycle 1 -> WAIT from cycle 2 -> rsp_valid the cycle after core_done is sampled.
- Latency, bypass path: gnt and rsp_valid both in cycle 1.
- Back-to-back: one IDLE cycle between transactions, so the minimum spacing between rsp_valid pulses is 2 cycles on the bypass path.
- Requester rules:
  - Hold req and operands stable until gnt.
  - Operands are don't-care after gnt.
  - If req is still high when the arbiter returns to IDLE, it is treated as a new request.
  - Dropping req before gnt withdraws the request.
- core_done outside WAIT is ignored.
- gnt, rsp_valid and core_start are never asserted for more than one cycle per transaction.
- Reset mid-transaction: immediate abort, no rsp_valid for the aborted request, priority pointer returns to its reset value.

Test Plan:
1. After reset, req=0001, A0=8, B0=8; core model returns done with res=8 after 3 cycles -> gnt=0001 and core_start in cycle 1, core_a=core_b=8, rsp_valid=0001, rsp_data=8, rsp_err=0.
2. req=1111 held, each op pair (12,8), core returns 4 -> grant order 0,1,2,3,0; each rsp_data=4; exactly one gnt bit per transaction.
3. After requester 2 is served, req=0101 -> requester 0 is granted next (wrap past 3), then requester 2.
4. req=0010, A1=0, B1=12 -> gnt=0010 and rsp_valid=0010 in cycle 1, rsp_data=12, err=0, core_start never asserted. Then A1=B1=0 -> rsp_data=0, rsp_err=1.
5. Core model never asserts done, TIMEOUT=64 -> rsp_valid with rsp_err=1 and rsp_data=0 exactly 64 cycles after entering WAIT. A late core_done in IDLE is ignored.
6. Assert rst=0 mid-WAIT -> all outputs 0 immediately, no rsp_valid. After release, req=1001 -> requester 0 is granted first.
